// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      REDIRECT = 2'd2
   } ctrlState_t;

   localparam int unsigned REG_ZERO = 0;
   localparam int unsigned PEN_W    = 3;

endpackage

// File: rtl/hazard_detect_unit.sv
// Combinational load-use comparator: a load in EX feeding the instruction in ID.
module hazard_detect_unit
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   output logic             load_use
);

   // $zero is never a real dependency, so a load targeting it cannot stall ID.
   assign load_use = ex_mem_read && (ex_rt != REG_W'(REG_ZERO)) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline; priority is MEM wait > redirect > load-use.
// Optional stall/flush statistics counters are built when PIPE_STALL_STATS_EN is defined.
module pipeline_hazard_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_W            = 5,
   parameter int REDIRECT_PENALTY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             mem_branch_taken,
   input  logic             mem_jump,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic             ex_mem_flush,
   output logic             mem_wb_bubble,
   output logic             busy
`ifdef PIPE_STALL_STATS_EN
   ,
   output logic [31:0]      stall_cycles,
   output logic [31:0]      flush_events
`endif
);

   localparam logic [PEN_W-1:0] PEN_RELOAD =
      (REDIRECT_PENALTY > 0) ? PEN_W'(REDIRECT_PENALTY - 1) : '0;

   ctrlState_t       state, stateNext;
   logic [PEN_W-1:0] penCnt, penCntNext;
   logic             memWait, redirectReq, redirectAccept, loadUse;

   hazard_detect_unit #(.REG_W(REG_W)) uHazard (
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .ex_mem_read (ex_mem_read),
      .ex_rt       (ex_rt),
      .load_use    (loadUse)
   );

   assign memWait        = mem_req && !mem_ready;
   assign redirectReq    = mem_branch_taken || mem_jump;
   assign redirectAccept = redirectReq && !memWait;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= RUN;
         penCnt <= '0;
      end else begin
         state  <= stateNext;
         penCnt <= penCntNext;
      end
   end

   always_comb begin
      stateNext  = state;
      penCntNext = penCnt;
      case (state)
         RUN, MEM_WAIT: begin
            if (memWait) begin
               stateNext = MEM_WAIT;
            end else if (redirectReq) begin
               stateNext  = (REDIRECT_PENALTY > 0) ? REDIRECT : RUN;
               penCntNext = PEN_RELOAD;
            end else begin
               stateNext = RUN;
            end
         end
         REDIRECT: begin
            // A data-memory wait freezes the penalty countdown along with the pipe.
            if (memWait) begin
               stateNext = REDIRECT;
            end else if (redirectReq) begin
               stateNext  = REDIRECT;
               penCntNext = PEN_RELOAD;
            end else if (penCnt == '0) begin
               stateNext = RUN;
            end else begin
               penCntNext = penCnt - 1'b1;
            end
         end
         default: begin
            stateNext  = RUN;
            penCntNext = '0;
         end
      endcase
   end

   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_write   = 1'b1;
      id_ex_flush   = 1'b0;
      ex_mem_write  = 1'b1;
      ex_mem_flush  = 1'b0;
      mem_wb_bubble = 1'b0;
      busy          = 1'b0;
      if (!reset) begin
         busy = (state != RUN);
         if (memWait) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
         end else if (redirectReq) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
         end else if (state == REDIRECT) begin
            if_id_flush = 1'b1;
         end else if (loadUse) begin
            // ID holds a bubble while in REDIRECT, so load-use only matters here.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
         end
      end
   end

`ifdef PIPE_STALL_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (!pc_write && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
         if (redirectAccept && (flush_events != '1)) flush_events <= flush_events + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller with REDIRECT_PENALTY=2.
module tb_pipeline_hazard_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rt, ex_mem_read, mem_branch_taken, mem_jump, mem_req, mem_ready;
   logic       pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
   logic       ex_mem_write, ex_mem_flush, mem_wb_bubble, busy;
`ifdef PIPE_STALL_STATS_EN
   logic [31:0] stall_cycles, flush_events;
`endif

   int checks = 0;
   int errors = 0;

   // Vector order: pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, bubble, busy
   localparam logic [8:0] DEF  = 9'b1_1_0_1_0_1_0_0_0;
   localparam logic [8:0] DEFB = 9'b1_1_0_1_0_1_0_0_1;
   localparam logic [8:0] LU   = 9'b0_0_0_1_1_1_0_0_0;
   localparam logic [8:0] RDR  = 9'b1_1_1_1_1_1_1_0_0;
   localparam logic [8:0] RDRB = 9'b1_1_1_1_1_1_1_0_1;
   localparam logic [8:0] PEN  = 9'b1_1_1_1_0_1_0_0_1;
   localparam logic [8:0] FRZ  = 9'b0_0_0_0_0_0_0_1_0;
   localparam logic [8:0] FRZB = 9'b0_0_0_0_0_0_0_1_1;

   pipeline_hazard_controller #(.REG_W(5), .REDIRECT_PENALTY(2)) dut (
      .clk              (clk),
      .reset            (reset),
      .id_rs            (id_rs),
      .id_rt            (id_rt),
      .id_uses_rt       (id_uses_rt),
      .ex_mem_read      (ex_mem_read),
      .ex_rt            (ex_rt),
      .mem_branch_taken (mem_branch_taken),
      .mem_jump         (mem_jump),
      .mem_req          (mem_req),
      .mem_ready        (mem_ready),
      .pc_write         (pc_write),
      .if_id_write      (if_id_write),
      .if_id_flush      (if_id_flush),
      .id_ex_write      (id_ex_write),
      .id_ex_flush      (id_ex_flush),
      .ex_mem_write     (ex_mem_write),
      .ex_mem_flush     (ex_mem_flush),
      .mem_wb_bubble    (mem_wb_bubble),
      .busy             (busy)
`ifdef PIPE_STALL_STATS_EN
      ,
      .stall_cycles     (stall_cycles),
      .flush_events     (flush_events)
`endif
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic mr, input logic [4:0] ert, input logic br,
                        input logic jm, input logic rq, input logic rd);
      id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mr; ex_rt = ert;
      mem_branch_taken = br; mem_jump = jm; mem_req = rq; mem_ready = rd;
   endtask

   task automatic idle();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Settle after the inputs change, compare controls, then advance one clock.
   task automatic step(input string tag, input logic [8:0] exp);
      logic [8:0] obs;
      #1;
      obs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
             ex_mem_write, ex_mem_flush, mem_wb_bubble, busy};
      check32(tag, {23'd0, obs}, {23'd0, exp});
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      step("reset_forced", DEF);
      reset = 1'b0;
      idle();                                                      step("idle", DEF);
      drive(5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0); step("lu_rs", LU);
      idle();                                                      step("lu_after", DEF);
      drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); step("lu_zero", DEF);
      drive(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0); step("lu_rt_unused", DEF);
      drive(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0); step("lu_rt_used", LU);

      // Taken branch with a two-cycle IF/ID penalty
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); step("br_flush", RDR);
      drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0); step("br_pen1_lu_ignored", PEN);
      idle();                                                      step("br_pen2", PEN);
      idle();                                                      step("br_done", DEF);

      reset = 1'b1; idle();                                        step("reset2", DEF);
      reset = 1'b0;
`ifdef PIPE_STALL_STATS_EN
      check32("stall_cleared", stall_cycles, 32'd0);
      check32("flush_cleared", flush_events, 32'd0);
`endif
      // Four-cycle memory wait, load-use overlapping the wait
      drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0); step("wait1_lu", FRZ);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); step("wait2", FRZB);
      drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0); step("wait3_lu", FRZB);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); step("wait4", FRZB);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); step("wait_done", DEFB);
      idle();                                                      step("wait_after", DEF);
`ifdef PIPE_STALL_STATS_EN
      check32("stall_after_wait", stall_cycles, 32'd4);
      check32("flush_after_wait", flush_events, 32'd0);
`endif

      // Second redirect while pen_cnt=1 reloads the penalty
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); step("rr_first", RDR);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); step("rr_second", RDRB);
      idle();                                                      step("rr_pen1", PEN);
      idle();                                                      step("rr_pen2", PEN);
      idle();                                                      step("rr_done", DEF);

      // Memory wait inside REDIRECT holds pen_cnt
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); step("rw_flush", RDR);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); step("rw_freeze", FRZB);
      idle();                                                      step("rw_pen1", PEN);
      idle();                                                      step("rw_pen2", PEN);
      idle();                                                      step("rw_done", DEF);

      // Redirect honoured in the memory completion cycle
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); step("wr_wait", FRZ);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1); step("wr_jump", RDRB);
      idle();                                                      step("wr_pen1", PEN);
      idle();                                                      step("wr_pen2", PEN);
      idle();                                                      step("wr_done", DEF);
`ifdef PIPE_STALL_STATS_EN
      check32("stall_total", stall_cycles, 32'd6);
      check32("flush_total", flush_events, 32'd4);
`endif

      // Reset abandons a memory wait
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); step("rst_wait", FRZ);
      reset = 1'b1;                                                step("rst_in_wait", DEF);
      reset = 1'b0; idle();                                        step("rst_run", DEF);
`ifdef PIPE_STALL_STATS_EN
      check32("stall_final", stall_cycles, 32'd0);
      check32("flush_final", flush_events, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
